// File: rtl/multdiv_pkg.sv
// Shared definitions for the unidad_multdiv multiply/divide unit:
// widths, operation and state encodings, divide-by-zero quotient.
package multdiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // Magnitude of a two's-complement value; passthrough for unsigned ops.
    function automatic logic [XLEN-1:0] mag(
        input logic [XLEN-1:0] x,
        input logic            sgn
    );
        return (sgn && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/unidad_multdiv_paso_division.sv
// Combinational restoring-division step: shift in one dividend bit,
// trial-subtract the divisor, keep or restore.
// Ports: i_rem partial remainder, i_bit dividend bit, i_div divisor,
//        o_rem next remainder, o_q quotient bit.
module paso_division
    import multdiv_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q
);

    logic [XLEN:0] w_sh;
    logic [XLEN:0] w_diff;

    // i_rem < i_div holds, so w_sh < 2*i_div and bit XLEN of the
    // difference is a clean borrow flag.
    assign w_sh   = {i_rem, i_bit};
    assign w_diff = w_sh - {1'b0, i_div};
    assign o_q    = ~w_diff[XLEN];
    assign o_rem  = o_q ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];

endmodule

// File: rtl/unidad_multdiv.sv
// MIPS multi-cycle multiply/divide unit with architectural HI/LO.
// Ports: clk, rst_n (sync, active-low), start/op/opA/opB launch an op;
//   wr_hi/wr_lo/wdata implement MTHI/MTLO; busy, done, hi, lo outputs.
// Option: FAST_MULT_EN makes MULT/MULTU single-cycle (skip CALC).
module unidad_multdiv
    import multdiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    op_e                r_op;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_b;
    logic               r_negq;
    logic               r_negr;
    logic               r_done;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;

    logic               w_sgn;
    logic               w_fast;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic [XLEN-1:0]    w_rem_nxt;
    logic               w_qbit;
    logic [XLEN:0]      w_sum;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_quot;
    logic [XLEN-1:0]    w_rem;

    // Even op codes are the signed variants.
    assign w_sgn   = ~op[0];
    assign w_mag_a = mag(opA, w_sgn);
    assign w_mag_b = mag(opB, w_sgn);

`ifdef FAST_MULT_EN
    assign w_fast = ~op[1];
`else
    assign w_fast = 1'b0;
`endif

    // Divide: r_acc = {partial remainder, dividend bits / quotient bits}.
    paso_division u_paso (
        .i_rem (r_acc[2*XLEN-1:XLEN]),
        .i_bit (r_acc[XLEN-1]),
        .i_div (r_b),
        .o_rem (w_rem_nxt),
        .o_q   (w_qbit)
    );

    // Multiply: r_acc = {partial product, remaining multiplier bits}.
    assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                 + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});

    assign w_prod = r_negq ? (~r_acc + 1'b1) : r_acc;
    assign w_quot = (r_b == '0) ? DIV0_QUOT
                  : (r_negq ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0]);
    assign w_rem  = r_negr ? (~r_acc[2*XLEN-1:XLEN] + 1'b1)
                           : r_acc[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_fast ? ST_FIN : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == CNT_W'(XLEN-1)) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_op   <= OP_MULT;
            r_acc  <= '0;
            r_b    <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op   <= op_e'(op);
                        r_b    <= w_mag_b;
                        r_negq <= w_sgn & (opA[XLEN-1] ^ opB[XLEN-1]);
                        r_negr <= w_sgn & opA[XLEN-1];
                        r_cnt  <= '0;
`ifdef FAST_MULT_EN
                        if (w_fast) begin
                            r_acc <= {{XLEN{1'b0}}, w_mag_a}
                                   * {{XLEN{1'b0}}, w_mag_b};
                        end else begin
                            r_acc <= {{XLEN{1'b0}}, w_mag_a};
                        end
`else
                        r_acc <= {{XLEN{1'b0}}, w_mag_a};
`endif
                    end else begin
                        if (wr_hi) r_hi <= wdata;
                        if (wr_lo) r_lo <= wdata;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op[1]) begin
                        r_acc <= {w_rem_nxt, r_acc[XLEN-2:0], w_qbit};
                    end else begin
                        r_acc <= {w_sum, r_acc[XLEN-1:1]};
                    end
                end
                ST_FIN: begin
                    if (r_op[1]) begin
                        r_lo <= w_quot;
                        r_hi <= w_rem;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_unidad_multdiv.sv
// Self-checking bench for unidad_multdiv: directed corner cases plus
// random operations against an arithmetic reference model.
module tb_unidad_multdiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

`ifdef FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    unidad_multdiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .opA   (opA),
        .opB   (opB),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the MIPS arithmetic rules.
    task automatic model(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa;
        int                 sb;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                sp = 64'(sa) * 64'(sb);
                {eh, el} = sp;
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                {eh, el} = up;
            end
            2'b10: begin
                if (b == 0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'h0;
                end else begin
                    el = sa / sb; eh = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endtask

    // Launch at edge E0; returns #1 after E0 with operands scrambled.
    task automatic go(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b);
        start = 1'b1; op = o; opA = a; opB = b;
        @(posedge clk); #1;
        start = 1'b0;
        opA = $urandom; opB = $urandom; op = 2'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        int lat;
        model(o, a, b, eh, el);
        go(o, a, b);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(o[1] ? DIV_LAT : MUL_LAT));
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        int          seen;

        rst_n = 1'b0; start = 1'b0; op = 2'b00;
        opA = '0; opB = '0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_hi_abs", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_neg_lo_abs", 64'(lo), 64'hFFFF_FFFA);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);

        run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo_abs", 64'(lo), 64'hFFFF_FFFD);
        chk("div_neg_hi_abs", 64'(hi), 64'hFFFF_FFFF);
        run("divu_7_2", 2'b11, 32'd7, 32'd2);
        run("divu_by0", 2'b11, 32'h1234_5678, 32'd0);
        chk("divu_by0_hi_abs", 64'(hi), 64'h1234_5678);
        run("div_by0", 2'b10, 32'h8765_4321, 32'd0);
        run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_abs", 64'(lo), 64'h8000_0000);
        run("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
        run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Start and MTHI pulses while busy must be ignored.
        go(2'b11, 32'd100, 32'd7);
        repeat (5) begin
            start = 1'b1; op = 2'b01; wr_hi = 1'b1; wdata = 32'hDEAD;
            @(posedge clk); #1;
        end
        start = 1'b0; wr_hi = 1'b0;
        wait_done(lat);
        chk("busy_ign_done", 64'(done), 64'd1);
        chk("busy_ign_lo", 64'(lo), 64'd14);
        chk("busy_ign_hi", 64'(hi), 64'd2);
        @(posedge clk); #1;
        wr_lo = 1'b1; wdata = 32'hBEEF;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'hBEEF);
        chk("mtlo_hi", 64'(hi), 64'd2);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mt_both_hi", 64'(hi), 64'h1234);
        chk("mt_both_lo", 64'(lo), 64'h1234);
        wr_lo = 1'b1; wdata = 32'h5555;
        go(2'b01, 32'd3, 32'd4);
        wr_lo = 1'b0;
        chk("start_wins_lo", 64'(lo), 64'h1234);
        wait_done(lat);
        chk("start_wins_res", 64'(lo), 64'd12);

        // Back-to-back: new op launched during the done cycle.
        run("b2b_first", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run("b2b_second", 2'b01, 32'hABCD_0123, 32'h0F0F_F0F0);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h7777;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        go(2'b01, 32'd5, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("midrst_nodone", 64'(seen), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
